// File: rtl/mips_mem_bridge_pkg.sv
// Shared definitions for the multicycle-MIPS memory bridge: FSM encoding,
// default abort timeout and the read data returned for failed accesses.
package mips_mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned CTR_W        = 8;
  localparam int unsigned TIMEOUT_DEF  = 255;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/mips_mem_bridge_timeout_ctr.sv
// Loadable down-counter that sticks at zero; o_zero marks the last permitted
// WAIT cycle before the bridge abandons a bus access.
module mem_timeout_ctr #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load on WAIT entry, count down while waiting, saturate at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mips_mem_bridge.sv
// Bridge between the multicycle controller and the unified memory: turns a
// single-state memory access into a req/ack transaction, stalls the
// processor until it completes, and flags misaligned or timed-out accesses.
module mips_mem_bridge
  import mips_mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irwrite,
  input  logic        iord,
  input  logic        memwrite,
  input  logic [31:0] adr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        err,
  input  logic        err_clr
);

  // Counter is loaded with TIMEOUT-1 and the abort fires on the WAIT cycle
  // in which it reads zero, giving exactly TIMEOUT WAIT cycles.
  localparam logic [CTR_W-1:0] W_LOAD = CTR_W'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_acc;
  logic        w_mis;
  logic        w_start;
  logic        w_mis_hit;
  logic        w_ack_hit;
  logic        w_abort;
  logic        w_dec;
  logic        w_ctr_zero;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_rd;
  logic        r_err;

  assign w_acc = irwrite | iord;
  assign w_mis = w_acc & (adr[1:0] != 2'b00);

  mem_timeout_ctr #(
    .W (CTR_W)
  ) u_ctr (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_start),
    .i_load_val (W_LOAD),
    .i_dec      (w_dec),
    .o_zero     (w_ctr_zero)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, stall and per-cycle event strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_mis_hit   = 1'b0;
    w_ack_hit   = 1'b0;
    w_abort     = 1'b0;
    w_dec       = 1'b0;
    stall       = 1'b0;
    case (r_state)
      IDLE: begin
        stall = w_acc;
        if (w_mis) begin
          w_mis_hit   = 1'b1;
          w_state_nxt = DONE;
        end else if (w_acc) begin
          w_start     = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        w_dec = ~bus_ack;
        if (bus_ack) begin
          w_ack_hit   = 1'b1;
          w_state_nxt = DONE;
        end else if (w_ctr_zero) begin
          w_abort     = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Bus request and its address/data/direction, held for the whole WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else if (w_start) begin
      r_bus_req   <= 1'b1;
      r_bus_we    <= memwrite;
      r_bus_addr  <= adr;
      r_bus_wdata <= wd;
    end else if (w_ack_hit || w_abort) begin
      r_bus_req   <= 1'b0;
    end
  end

  // Read data: memory data on a read ack, ERR_DATA on a failed access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd <= '0;
    end else if (w_mis_hit) begin
      r_rd <= ERR_DATA;
    end else if (w_ack_hit && !r_bus_we) begin
      r_rd <= bus_rdata;
    end else if (w_abort && !r_bus_we) begin
      r_rd <= ERR_DATA;
    end
  end

  // Sticky error; a new error event wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_mis_hit || w_abort) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign rd        = r_rd;
  assign err       = r_err;

endmodule

// File: tb/tb_mips_mem_bridge.sv
// Self-checking bench for mips_mem_bridge: table of accesses with a small
// memory responder, expected results queued per access, plus hand-written
// reset-mid-WAIT and spurious-ack sequences.
module tb_mips_mem_bridge;

  localparam int unsigned TO = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        irwrite, iord, memwrite;
  logic [31:0] adr, wd, rd;
  logic        stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        err, err_clr;

  mips_mem_bridge #(
    .TIMEOUT  (TO),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .irwrite   (irwrite),
    .iord      (iord),
    .memwrite  (memwrite),
    .adr       (adr),
    .wd        (wd),
    .rd        (rd),
    .stall     (stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        irw, io, mw;
    logic [31:0] a, d;
    int          ack_dly;   // WAIT cycle index carrying the ack; -1 = never
    logic [31:0] rdata;
    logic        clr_before, clr_during;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_stall, exp_req;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          stall_n, req_n;
    logic        we;
    logic [31:0] addr, wdata;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[11];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic irw, input logic io, input logic mw,
                              input logic [31:0] a, input logic [31:0] d,
                              input int ack_dly, input logic [31:0] rdata,
                              input logic cb, input logic cd,
                              input logic [31:0] exp_rd, input logic exp_err,
                              input int exp_stall, input int exp_req);
    vec_t v;
    v.irw = irw; v.io = io; v.mw = mw; v.a = a; v.d = d;
    v.ack_dly = ack_dly; v.rdata = rdata;
    v.clr_before = cb; v.clr_during = cd;
    v.exp_rd = exp_rd; v.exp_err = exp_err;
    v.exp_stall = exp_stall; v.exp_req = exp_req;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at/just after a falling edge; returns just after a falling edge.
  task automatic pulse_clr(input string tag);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk({tag, "_errclr"}, 32'(err), 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    exp_t g;
    int   stall_n = 0;
    int   req_n   = 0;
    int   cyc     = 0;
    logic bus_ok  = 1'b1;
    logic done    = 1'b0;
    if (v.clr_before) pulse_clr(tag);
    irwrite = v.irw; iord = v.io; memwrite = v.mw;
    adr = v.a; wd = v.d; err_clr = v.clr_during; bus_ack = 1'b0;
    e.rd = v.exp_rd; e.err = v.exp_err; e.stall_n = v.exp_stall; e.req_n = v.exp_req;
    e.we = v.mw; e.addr = v.a; e.wdata = v.d;
    sb.push_back(e);
    while (!done && cyc < 600) begin
      #1;
      bus_ack   = 1'b0;
      bus_rdata = 32'hA5A5_A5A5;
      if (bus_req) begin
        req_n++;
        if (bus_addr !== e.addr || bus_we !== e.we || bus_wdata !== e.wdata) bus_ok = 1'b0;
      end
      if (!stall) begin
        done = 1'b1;
      end else begin
        stall_n++;
        if (bus_req && v.ack_dly >= 0 && (req_n - 1) == v.ack_dly) begin
          bus_ack   = 1'b1;
          bus_rdata = v.rdata;
        end
        @(negedge clk);
        cyc++;
      end
    end
    g = sb.pop_front();
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_done: stall still high after %0d cycles, expected release", tag, cyc);
    end else begin
      chk({tag, "_rd"},    rd,            g.rd);
      chk({tag, "_err"},   32'(err),      32'(g.err));
      chk({tag, "_stall"}, 32'(stall_n),  32'(g.stall_n));
      chk({tag, "_req"},   32'(req_n),    32'(g.req_n));
      chk({tag, "_bus"},   32'(bus_ok),   32'h1);
    end
    irwrite = 1'b0; iord = 1'b0; memwrite = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_idle_req"},   32'(bus_req), 32'h0);
    chk({tag, "_idle_stall"}, 32'(stall),   32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    //                irw io mw adr           wd            dly rdata         cb cd exp_rd        err st rq
    vecs[0]  = mk(1, 0, 0, 32'h0000_0040, 32'h0,         0, 32'h8C02_0004, 0, 0, 32'h8C02_0004, 0, 2, 1);
    vecs[1]  = mk(0, 1, 1, 32'h0000_0100, 32'h1234_5678, 5, 32'hFFFF_0000, 0, 0, 32'h8C02_0004, 0, 7, 6);
    vecs[2]  = mk(0, 1, 0, 32'h0000_0200, 32'h0,         2, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D, 0, 4, 3);
    vecs[3]  = mk(0, 1, 0, 32'h0000_0204, 32'h0,        -1, 32'h0,         0, 0, 32'hDEAD_BEEF, 1, 7, 6);
    vecs[4]  = mk(1, 0, 0, 32'h0000_0044, 32'h0,         1, 32'h0123_4567, 0, 0, 32'h0123_4567, 1, 3, 2);
    vecs[5]  = mk(0, 1, 0, 32'h0000_0102, 32'h0,         0, 32'h1111_1111, 0, 0, 32'hDEAD_BEEF, 1, 1, 0);
    vecs[6]  = mk(0, 1, 0, 32'h0000_0008, 32'h0,         0, 32'h55AA_55AA, 1, 0, 32'h55AA_55AA, 0, 2, 1);
    vecs[7]  = mk(0, 1, 1, 32'h0000_0300, 32'h0000_00AA,-1, 32'h0,         0, 0, 32'h55AA_55AA, 1, 7, 6);
    vecs[8]  = mk(1, 0, 0, 32'h0000_0301, 32'h0,         0, 32'h0,         1, 1, 32'hDEAD_BEEF, 1, 1, 0);
    vecs[9]  = mk(1, 0, 0, 32'h0000_0080, 32'h0,         1, 32'h0F0F_0F0F, 0, 0, 32'h0F0F_0F0F, 0, 3, 2);
    vecs[10] = mk(1, 0, 0, 32'h0000_0084, 32'h0,         0, 32'h3C3C_3C3C, 0, 0, 32'h3C3C_3C3C, 0, 2, 1);

    reset = 1'b0; irwrite = 1'b0; iord = 1'b0; memwrite = 1'b0;
    adr = '0; wd = '0; bus_ack = 1'b0; bus_rdata = '0; err_clr = 1'b0;
    #2;
    chk("rst_req",   32'(bus_req), 32'h0);
    chk("rst_we",    32'(bus_we),  32'h0);
    chk("rst_addr",  bus_addr,     32'h0);
    chk("rst_wdata", bus_wdata,    32'h0);
    chk("rst_rd",    rd,           32'h0);
    chk("rst_err",   32'(err),     32'h0);
    chk("rst_stall", 32'(stall),   32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset while a fetch is waiting on the bus.
    irwrite = 1'b1; adr = 32'h0000_0080; bus_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid_wait_req", 32'(bus_req), 32'h1);
    #1;
    reset = 1'b0; irwrite = 1'b0;
    #1;
    chk("arst_req",   32'(bus_req), 32'h0);
    chk("arst_stall", 32'(stall),   32'h0);
    chk("arst_err",   32'(err),     32'h0);
    chk("arst_rd",    rd,           32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    run_vec(vecs[9], "v9");

    // Ack pulse while idle must not disturb rd or the FSM.
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("spur_rd",    rd,           32'h0F0F_0F0F);
    chk("spur_stall", 32'(stall),   32'h0);
    chk("spur_req",   32'(bus_req), 32'h0);
    run_vec(vecs[10], "v10");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_mem_bridge.md
Name: mips_mem_bridge

Overview:
- Sits between the multicycle controller/datapath and the external unified instruction/data memory.
- Turns the controller's single-state memory accesses (Fetch, MemRead, Mem_Write) into a req/ack bus transaction of variable latency.
- Drives `stall` back to freeze all processor state (controller state register, PC, IR, register file) until the access completes.
- Adds an alignment check, a timeout, and a sticky error flag.

Parameters:
- `TIMEOUT`, 255, WAIT cycles without `bus_ack` before the access is abandoned (1..255).
- `ERR_DATA`, 32'hDEAD_BEEF, read data returned for an aborted or misaligned read.

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `irwrite`  in  1  controller: instruction fetch this state
- `iord`  in  1  controller: data access this state (MemRead or Mem_Write)
- `memwrite`  in  1  controller: write access
- `adr`  in  32  datapath memory address (PC or ALUOut)
- `wd`  in  32  datapath write data (B register)
- `rd`  out  32  read data to IR/data register; valid when `stall`=0 in DONE
- `stall`  out  1  processor hold
- `bus_req`  out  1  bus request, registered
- `bus_we`  out  1  bus write enable, registered
- `bus_addr`  out  32  bus address, registered
- `bus_wdata`  out  32  bus write data, registered
- `bus_ack`  in  1  memory completion, single-cycle pulse
- `bus_rdata`  in  32  memory read data, valid with `bus_ack`
- `err`  out  1  sticky error (timeout or misaligned)
- `err_clr`  in  1  synchronous clear of `err`

Behaviour:
- `acc` = `irwrite` | `iord`.
- `mis` = `acc` & (`adr[1:0]` != 0).
- Reset (async, `reset`=0): state IDLE; `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `rd`, `err` and the timeout counter all 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE & `acc` & !`mis`:
  - latch `bus_addr`=`adr`, `bus_wdata`=`wd`, `bus_we`=`memwrite`;
  - set `bus_req`=1; clear counter; go to WAIT.
- IDLE & `mis`:
  - no bus transaction; set `err`; `rd`=`ERR_DATA`;
  - go to DONE.
- WAIT & `bus_ack`:
  - `bus_req`=0;
  - if !`bus_we`, `rd`=`bus_rdata`; writes leave `rd` unchanged;
  - go to DONE.
- WAIT & !`bus_ack`:
  - counter++;
  - when counter reaches `TIMEOUT`-1 with no ack: `bus_req`=0, `err`=1, `rd`=`ERR_DATA` for a read; go to DONE.
- DONE: always go to IDLE next cycle. `acc` is ignored here; the controller leaves the access state on this edge.
- `stall` (combinational) = (IDLE & `acc`) | WAIT. It is 0 in DONE and in IDLE with no access.
- Latency, zero-wait memory: access state entered at cycle 0 with `stall`=1; cycle 1 is WAIT with `bus_req`=1 and `bus_ack`=1, `stall`=1; cycle 2 is DONE with `stall`=0 and `rd` valid, and the processor commits.
  - Minimum 2 stall cycles per access.
  - N-cycle ack delay gives N+2 stall cycles.
- `bus_req` stays high, with address/data/we stable, from WAIT entry until the ack cycle inclusive. It never re-asserts in the cycle after an ack.
- `bus_ack` outside WAIT is ignored; it does not alter `rd` or the state.
- `err`:
  - sets on timeout or misaligned access;
  - `err_clr`=1 clears it;
  - a set event and `err_clr` in the same cycle gives set priority.
- Reset mid-WAIT: `bus_req` drops immediately (async); the transaction is abandoned and the memory must tolerate this.
- Counter is 8 bits and saturates; it never wraps.

Decomposition:
- Shared package holds the state encodings (IDLE=2'd0, WAIT=2'd1, DONE=2'd2), `ERR_DATA` and the default `TIMEOUT`.
- One sub-module: `mem_timeout_ctr`, a loadable saturating down-counter with a `zero` flag, used for WAIT.

Test Plan:
- Fetch, `adr`=0x0000_0040, ack 1 cycle after `bus_req`, `bus_rdata`=0x8C02_0004 → `stall` high 2 cycles; `rd`=0x8C02_0004 in DONE; `bus_addr`=0x40, `bus_we`=0.
- sw, `iord`=1, `memwrite`=1, `adr`=0x100, `wd`=0x1234_5678, ack delayed 5 cycles → `bus_we`=1 and `bus_wdata`=0x1234_5678 held 6 cycles; `stall` high 7 cycles; `rd` unchanged.
- lw with no ack, `TIMEOUT`=4 → `bus_req` drops after 4 WAIT cycles; `err`=1; `rd`=0xDEAD_BEEF; `stall` low in DONE.
- lw with `adr`=0x0000_0102 → no `bus_req`; `stall` for 1 cycle; `err`=1; `rd`=0xDEAD_BEEF. `err_clr` pulse → `err`=0.
- `reset` asserted mid-WAIT → `bus_req`, `stall` and `err` go to 0 immediately; state IDLE; a fresh fetch after release completes normally.
- Spurious `bus_ack` in IDLE with `bus_rdata`=0xFFFF_FFFF → `rd` and state unchanged; following fetch returns the correct data.
